// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing definitions used by both the timing generator and the
// receive-side sync decoder.
//   coord_t         : 12-bit pixel / line coordinate and period type
//   CNT_MAX         : saturation value of every 12-bit timing counter
//   VGA_*           : default 640x480@60 timing (active window start, active
//                     size, totals and sync widths)
//   lock_state_e    : per-axis lock state (UNLOCKED / LOCKED)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t CNT_MAX = '1;

    // Default 640x480 timing; the generator and the decoder share these.
    localparam int VGA_X_START  = 144;
    localparam int VGA_Y_START  = 35;
    localparam int VGA_H_ACT    = 640;
    localparam int VGA_V_ACT    = 480;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_SYNC_W = 96;
    localparam int VGA_V_SYNC_W = 2;

    typedef enum logic {
        AXIS_UNLOCKED = 1'b0,
        AXIS_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/sync_period_meter.sv
// ---------------------------------------------------------------------------
// sync_period_meter
// Measures the period between falling edges of an active-low sync signal and
// declares lock once LOCK_N consecutive periods equal their predecessor.
// Used once for the horizontal axis (counting pixel clocks) and once for the
// vertical axis (counting line starts).
// Ports:
//   clk_i      : clock
//   srst_i     : synchronous active-high reset
//   sync_s1_i  : first-stage registered sample of the sync input
//   tick_i     : counter advance enable (every clock, or once per line)
//   clear_i    : external loss-of-lock (clears the match count)
//   fall_o     : combinational sync fall (stage2=1, stage1=0)
//   cnt_o      : position counter, 0 on the cycle after a fall, saturating
//   total_o    : last measured period (counter value + 1 at the fall)
//   start_o    : registered single-cycle pulse for each detected fall
//   locked_o   : axis is locked
// ---------------------------------------------------------------------------
module sync_period_meter
    import vga_pkg::*;
#(
    parameter int LOCK_N = 4
) (
    input  logic   clk_i,
    input  logic   srst_i,
    input  logic   sync_s1_i,
    input  logic   tick_i,
    input  logic   clear_i,
    output logic   fall_o,
    output coord_t cnt_o,
    output coord_t total_o,
    output logic   start_o,
    output logic   locked_o
);

    localparam int              MW         = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]   MATCH_FULL = MW'(LOCK_N);

    logic          sync_s2_q;
    coord_t        cnt_q,   cnt_d;
    coord_t        total_q, total_d;
    coord_t        period;
    logic [MW-1:0] match_q, match_d;
    logic          seen_q,  seen_d;
    logic          start_q;
    lock_state_e   state_q, state_d;
    logic          fall;
    logic          sat;

    assign fall = sync_s2_q & ~sync_s1_i;
    assign sat  = (cnt_q == CNT_MAX);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_s2_q <= 1'b1;
            cnt_q     <= '0;
            total_q   <= '0;
            match_q   <= '0;
            seen_q    <= 1'b0;
            start_q   <= 1'b0;
            state_q   <= AXIS_UNLOCKED;
        end else begin
            sync_s2_q <= sync_s1_i;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            match_q   <= match_d;
            seen_q    <= seen_d;
            start_q   <= fall;
            state_q   <= state_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        match_d = match_q;
        seen_d  = seen_q;
        period  = cnt_q + 1'b1;
        state_d = state_q;

        if (fall) begin
            cnt_d   = '0;
            total_d = period;
            seen_d  = 1'b1;
            // The first fall after reset only establishes a reference period.
            if (seen_q) begin
                if (period == total_q) begin
                    match_d = (match_q == MATCH_FULL) ? match_q : match_q + 1'b1;
                end else begin
                    match_d = '0;
                end
            end
        end else if (tick_i && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A saturated counter means the sync has gone away; this overrides
        // whatever the fall logic decided in the same cycle.
        if (sat || clear_i) begin
            match_d = '0;
        end

        state_d = (match_d == MATCH_FULL) ? AXIS_LOCKED : AXIS_UNLOCKED;
    end

    assign fall_o   = fall;
    assign cnt_o    = cnt_q;
    assign total_o  = total_q;
    assign start_o  = start_q;
    assign locked_o = (state_q == AXIS_LOCKED);

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing decoder. Recovers X/Y coordinates of each pixel,
// flags the active window once H and V timing are locked, measures line and
// frame lengths and emits line/frame start pulses. Fixed 2-clock latency from
// input sample to every output.
// Ports:
//   iCLK, iRST                  : pixel clock, synchronous active-high reset
//   iVGA_H_SYNC, iVGA_V_SYNC    : active-low syncs
//   iRed, iGreen, iBlue         : 10-bit pixel data
//   oX, oY                      : active-area coordinates (0 outside window)
//   oActive                     : pixel inside active window and locked
//   oRed, oGreen, oBlue         : delayed pixel data, 0 outside window
//   oLine_Start, oFrame_Start   : one-cycle pulses on H / V sync fall
//   oH_Total, oV_Total          : last line period (clocks) / frame (lines)
//   oLocked                     : H and V both locked
// ---------------------------------------------------------------------------
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int X_START  = VGA_X_START,
    parameter int Y_START  = VGA_Y_START,
    parameter int H_ACT    = VGA_H_ACT,
    parameter int V_ACT    = VGA_V_ACT,
    parameter int H_LOCK_N = 4,
    parameter int V_LOCK_N = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVGA_H_SYNC,
    input  logic        iVGA_V_SYNC,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    output logic [11:0] oX,
    output logic [11:0] oY,
    output logic        oActive,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue,
    output logic        oLine_Start,
    output logic        oFrame_Start,
    output logic [11:0] oH_Total,
    output logic [11:0] oV_Total,
    output logic        oLocked
);

    localparam coord_t X_LO = coord_t'(X_START);
    localparam coord_t X_HI = coord_t'(X_START + H_ACT);
    localparam coord_t Y_LO = coord_t'(Y_START);
    localparam coord_t Y_HI = coord_t'(Y_START + V_ACT);

    // Stage 1: sync and pixel samples. The pixel gets a second stage so it
    // lines up with the counters, which move one edge after the sample.
    logic        h_s1_q;
    logic        v_s1_q;
    logic [29:0] rgb_s1_q;
    logic [29:0] rgb_s2_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_s1_q   <= 1'b1;
            v_s1_q   <= 1'b1;
            rgb_s1_q <= '0;
            rgb_s2_q <= '0;
        end else begin
            h_s1_q   <= iVGA_H_SYNC;
            v_s1_q   <= iVGA_V_SYNC;
            rgb_s1_q <= {iRed, iGreen, iBlue};
            rgb_s2_q <= rgb_s1_q;
        end
    end

    logic   h_fall;
    coord_t h_cnt;
    coord_t h_total;
    logic   h_start;
    logic   h_locked;
    logic   h_sat;

    logic   v_fall_unused;
    coord_t v_cnt;
    coord_t v_total;
    logic   v_start;
    logic   v_locked;

    sync_period_meter #(
        .LOCK_N (H_LOCK_N)
    ) u_h_meter (
        .clk_i     (iCLK),
        .srst_i    (iRST),
        .sync_s1_i (h_s1_q),
        .tick_i    (1'b1),
        .clear_i   (1'b0),
        .fall_o    (h_fall),
        .cnt_o     (h_cnt),
        .total_o   (h_total),
        .start_o   (h_start),
        .locked_o  (h_locked)
    );

    // A saturated line counter means H sync is gone, which invalidates V too.
    assign h_sat = (h_cnt == CNT_MAX);

    sync_period_meter #(
        .LOCK_N (V_LOCK_N)
    ) u_v_meter (
        .clk_i     (iCLK),
        .srst_i    (iRST),
        .sync_s1_i (v_s1_q),
        .tick_i    (h_fall),
        .clear_i   (h_sat),
        .fall_o    (v_fall_unused),
        .cnt_o     (v_cnt),
        .total_o   (v_total),
        .start_o   (v_start),
        .locked_o  (v_locked)
    );

    // Output stage
    logic        locked_q,  locked_d;
    logic        active_q,  active_d;
    coord_t      x_q,       x_d;
    coord_t      y_q,       y_d;
    logic [29:0] rgb_q,     rgb_d;
    logic        in_x;
    logic        in_y;

    always_comb begin
        locked_d = h_locked & v_locked;
        in_x     = (h_cnt >= X_LO) && (h_cnt < X_HI);
        in_y     = (v_cnt >= Y_LO) && (v_cnt < Y_HI);
        active_d = locked_d & in_x & in_y;
        x_d      = active_d ? (h_cnt - X_LO) : '0;
        y_d      = active_d ? (v_cnt - Y_LO) : '0;
        rgb_d    = active_d ? rgb_s2_q : '0;
    end

    logic   line_start_q;
    logic   frame_start_q;
    coord_t h_total_q;
    coord_t v_total_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            locked_q      <= 1'b0;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_total_q     <= '0;
            v_total_q     <= '0;
        end else begin
            locked_q      <= locked_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            line_start_q  <= h_start;
            frame_start_q <= v_start;
            h_total_q     <= h_total;
            v_total_q     <= v_total;
        end
    end

    assign oX           = x_q;
    assign oY           = y_q;
    assign oActive      = active_q;
    assign oRed         = rgb_q[29:20];
    assign oGreen       = rgb_q[19:10];
    assign oBlue        = rgb_q[9:0];
    assign oLine_Start  = line_start_q;
    assign oFrame_Start = frame_start_q;
    assign oH_Total     = h_total_q;
    assign oV_Total     = v_total_q;
    assign oLocked      = locked_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
// Drives a small-geometry VGA-like stream (40 clk lines, 12-line frames) with
// random pixel data, line-length jitter, a misaligned V sync, a mid-frame
// reset and an H sync dropout. Every output is compared each cycle against a
// reference model computed from fall positions and period streaks.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int XS    = 8;
    localparam int YS    = 3;
    localparam int HA    = 24;
    localparam int VA    = 6;
    localparam int HLN   = 4;
    localparam int VLN   = 2;
    localparam int H_TOT = 40;
    localparam int HS_W  = 4;
    localparam int V_TOT = 12;
    localparam int VS_W  = 2;

    logic        clk;
    logic        rst;
    logic        hs;
    logic        vs;
    logic [9:0]  red;
    logic [9:0]  green;
    logic [9:0]  blue;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        o_active;
    logic [9:0]  o_red;
    logic [9:0]  o_green;
    logic [9:0]  o_blue;
    logic        o_line_start;
    logic        o_frame_start;
    logic [11:0] o_h_total;
    logic [11:0] o_v_total;
    logic        o_locked;

    vga_sync_decoder #(
        .X_START  (XS),
        .Y_START  (YS),
        .H_ACT    (HA),
        .V_ACT    (VA),
        .H_LOCK_N (HLN),
        .V_LOCK_N (VLN)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iVGA_H_SYNC  (hs),
        .iVGA_V_SYNC  (vs),
        .iRed         (red),
        .iGreen       (green),
        .iBlue        (blue),
        .oX           (o_x),
        .oY           (o_y),
        .oActive      (o_active),
        .oRed         (o_red),
        .oGreen       (o_green),
        .oBlue        (o_blue),
        .oLine_Start  (o_line_start),
        .oFrame_Start (o_frame_start),
        .oH_Total     (o_h_total),
        .oV_Total     (o_v_total),
        .oLocked      (o_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state: sample index of the last H fall, line count
    // since the last V fall, reference periods and equal-period streaks.
    int m_h_last;
    int m_vline;
    int m_h_streak;
    int m_v_streak;
    int m_h_total;
    int m_v_total;
    bit m_h_seen;
    bit m_v_seen;
    bit m_h_prev;
    bit m_v_prev;

    // Reset at edge r: the reset-value stage acts as a virtual sample at r,
    // one position past a virtual fall at r-1.
    task automatic model_reset(input int r);
        m_h_last   = r - 1;
        m_vline    = 0;
        m_h_streak = 0;
        m_v_streak = 0;
        m_h_total  = 0;
        m_v_total  = 0;
        m_h_seen   = 1'b0;
        m_v_seen   = 1'b0;
        m_h_prev   = 1'b1;
        m_v_prev   = 1'b1;
    endtask

    task automatic model_sample(input int t, input logic h, input logic v,
                                input logic [29:0] pix, output logic [81:0] e);
        int hp_prev;
        int vp_prev;
        int hp;
        int vp;
        int per;
        bit hf;
        bit vf;
        bit lk;
        bit act;
        hp_prev = t - 1 - m_h_last;
        if (hp_prev > 4095) hp_prev = 4095;
        vp_prev = m_vline;
        hf = m_h_prev && !h;
        vf = m_v_prev && !v;
        if (hf) begin
            per = (hp_prev + 1) % 4096;
            if (m_h_seen)
                m_h_streak = (per == m_h_total) ? ((m_h_streak < HLN) ? m_h_streak + 1 : HLN) : 0;
            m_h_seen  = 1'b1;
            m_h_total = per;
            m_h_last  = t;
        end
        if (vf) begin
            per = (vp_prev + 1) % 4096;
            if (m_v_seen)
                m_v_streak = (per == m_v_total) ? ((m_v_streak < VLN) ? m_v_streak + 1 : VLN) : 0;
            m_v_seen  = 1'b1;
            m_v_total = per;
            m_vline   = 0;
        end else if (hf && m_vline < 4095) begin
            m_vline++;
        end
        if (hp_prev == 4095) begin
            m_h_streak = 0;
            m_v_streak = 0;
        end
        if (vp_prev == 4095) m_v_streak = 0;
        hp = t - m_h_last;
        if (hp > 4095) hp = 4095;
        vp  = m_vline;
        lk  = (m_h_streak == HLN) && (m_v_streak == VLN);
        act = lk && (hp >= XS) && (hp < XS + HA) && (vp >= YS) && (vp < YS + VA);
        e = {act, lk, hf, vf,
             act ? 12'(hp - XS) : 12'd0,
             act ? 12'(vp - YS) : 12'd0,
             act ? pix : 30'd0,
             12'(m_h_total), 12'(m_v_total)};
        m_h_prev = h;
        m_v_prev = v;
    endtask

    int          edge_n = 0;
    logic [81:0] exp_ring [4];

    // One clock: drive inputs on the falling edge, then after the rising
    // edge update the model and compare outputs due at this edge.
    task automatic step(input logic rst_v, input logic h, input logic v);
        logic [29:0] pix;
        logic [81:0] e;
        logic [81:0] obs;
        pix = 30'($urandom);
        @(negedge clk);
        rst = rst_v;
        hs  = h;
        vs  = v;
        {red, green, blue} = pix;
        @(posedge clk);
        #1;
        if (rst_v) begin
            model_reset(edge_n);
            exp_ring[edge_n % 4]       = '0;
            exp_ring[(edge_n + 1) % 4] = '0;
            exp_ring[(edge_n + 2) % 4] = '0;
        end else begin
            model_sample(edge_n, h, v, pix, e);
            exp_ring[(edge_n + 2) % 4] = e;
        end
        obs = {o_active, o_locked, o_line_start, o_frame_start, o_x, o_y,
               o_red, o_green, o_blue, o_h_total, o_v_total};
        check($sformatf("cyc%0d", edge_n), 96'(obs), 96'(exp_ring[edge_n % 4]));
        edge_n++;
    endtask

    // V level is v_a for the first `split` clocks of the line, v_b after.
    task automatic emit_line(input int len, input logic v_a, input int split, input logic v_b);
        for (int i = 0; i < len; i++) begin
            step(1'b0, (i < HS_W) ? 1'b0 : 1'b1, (i < split) ? v_a : v_b);
        end
    endtask

    task automatic emit_frame(input bit jitter);
        int len;
        logic vl;
        for (int l = 0; l < V_TOT; l++) begin
            len = H_TOT;
            if (jitter && $urandom_range(0, 7) == 0) len = H_TOT - 2 + int'($urandom_range(0, 4));
            vl = (l < VS_W) ? 1'b0 : 1'b1;
            emit_line(len, vl, 0, vl);
        end
    endtask

    // V sync falls mid-line rather than together with H sync.
    task automatic emit_vmid_frame();
        emit_line(H_TOT, 1'b1, 20, 1'b0);
        emit_line(H_TOT, 1'b0, 0, 1'b0);
        emit_line(H_TOT, 1'b0, 20, 1'b1);
        for (int l = 3; l < V_TOT; l++) emit_line(H_TOT, 1'b1, 0, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        hs    = 1'b1;
        vs    = 1'b1;
        red   = '0;
        green = '0;
        blue  = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        check("reset_locked", 96'(o_locked), 96'(0));
        check("reset_htotal", 96'(o_h_total), 96'(0));

        // Clean stream: H locks within a few lines, V after four frame falls.
        repeat (6) emit_frame(1'b0);
        check("std_locked", 96'(o_locked), 96'(1));
        check("std_htotal", 96'(o_h_total), 96'(H_TOT));
        check("std_vtotal", 96'(o_v_total), 96'(V_TOT));

        repeat (8) emit_frame(1'b1);
        emit_vmid_frame();
        repeat (4) emit_frame(1'b0);

        // Reset mid-frame while locked.
        for (int l = 0; l < 5; l++) emit_line(H_TOT, (l < VS_W) ? 1'b0 : 1'b1, 0, (l < VS_W) ? 1'b0 : 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("midrst_locked", 96'(o_locked), 96'(0));
        check("midrst_vtotal", 96'(o_v_total), 96'(0));
        repeat (6) emit_frame(1'b0);
        check("relock_locked", 96'(o_locked), 96'(1));

        // H sync dropout: counter saturates and lock is lost.
        repeat (4200) step(1'b0, 1'b1, 1'b1);
        check("sat_locked", 96'(o_locked), 96'(0));
        check("sat_active", 96'(o_active), 96'(0));
        repeat (6) emit_frame(1'b0);
        check("satrec_locked", 96'(o_locked), 96'(1));
        check("satrec_htotal", 96'(o_h_total), 96'(H_TOT));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
